// File: rtl/ps2key_evq.sv
// rtl/ps2key_evq.sv - PS/2 keyboard receiver folding E0/F0 prefixes into key events
// Deglitched clock, checked 11-bit deframer with timeout, FWFT event FIFO with valid/ready.
module ps2key_evq #(
   parameter int CLK_MHZ    = 50,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          ps2_key_clk,
   input  logic                          ps2_key_data,
   output logic [9:0]                    evt_data,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    led,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          overflow
);
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int LW      = PW + 1;
   localparam int TMO_CYC = CLK_MHZ * TIMEOUT_US;
   localparam int TW      = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic [7:0]    flt_cnt_q, flt_cnt_d;
   logic          flt_clk_q, flt_clk_d;
   logic          fall_q, fall_d;
   state_t        state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shreg_q, shreg_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic          err_parity_q, err_parity_d, err_frame_q, err_frame_d;
   logic [7:0]    led_q, led_d;
   logic          overflow_q, overflow_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [9:0]    mem_q [FIFO_DEPTH];

   logic       dat_bit, tmo_hit, frame_err, parity_err, byte_ok;
   logic       push, pop, full, push_ok;
   logic [9:0] evt_d;

   assign dat_bit = dat_sync_q[1];
   assign tmo_hit = (state_q == SHIFT) && !fall_q && (tmo_q == TW'(TMO_CYC - 1));

   // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_key_clk};
      dat_sync_d = {dat_sync_q[0], ps2_key_data};
      flt_clk_d  = flt_clk_q;
      flt_cnt_d  = '0;
      if (clk_sync_q[1] != flt_clk_q) begin
         if (flt_cnt_q == 8'(FILTER_LEN - 1)) flt_clk_d = clk_sync_q[1];
         else                                 flt_cnt_d = flt_cnt_q + 8'd1;
      end
      fall_d = flt_clk_q & ~flt_clk_d;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      tmo_d     = '0;
      case (state_q)
         IDLE: begin
            if (fall_q && !dat_bit) begin
               state_d   = SHIFT;
               bit_cnt_d = 4'd1;
            end
         end
         SHIFT: begin
            if (fall_q) begin
               shreg_d   = {dat_bit, shreg_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd10) state_d = CHECK;
            end else if (tmo_hit) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // shreg_q holds {stop, parity, data[7:0]} once the stop bit has been shifted in.
   always_comb begin
      frame_err  = 1'b0;
      parity_err = 1'b0;
      byte_ok    = 1'b0;
      case (state_q)
         IDLE:  frame_err = fall_q & dat_bit;
         SHIFT: frame_err = tmo_hit;
         CHECK: begin
            if (!shreg_q[9])          frame_err  = 1'b1;
            else if (!(^shreg_q[8:0])) parity_err = 1'b1;
            else                      byte_ok    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ext_d = ext_q;
      brk_d = brk_q;
      led_d = led_q;
      push  = 1'b0;
      evt_d = {ext_q, brk_q, shreg_q[7:0]};
      if (frame_err || parity_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_ok) begin
         if (shreg_q[7:0] == 8'hE0)      ext_d = 1'b1;
         else if (shreg_q[7:0] == 8'hF0) brk_d = 1'b1;
         else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q) led_d = shreg_q[7:0];
         end
      end
      pop          = (level_q != '0) && evt_ready;
      full         = (level_q == LW'(FIFO_DEPTH));
      push_ok      = push && (!full || pop);
      wr_ptr_d     = wr_ptr_q + PW'(push_ok);
      rd_ptr_d     = rd_ptr_q + PW'(pop);
      level_d      = level_q + LW'(push_ok) - LW'(pop);
      overflow_d   = overflow_q | (push & ~push_ok);
      err_parity_d = parity_err;
      err_frame_d  = frame_err;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         clk_sync_q   <= 2'b11;
         dat_sync_q   <= 2'b11;
         flt_cnt_q    <= '0;
         flt_clk_q    <= 1'b1;
         fall_q       <= 1'b0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         tmo_q        <= '0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         led_q        <= '0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         flt_cnt_q    <= flt_cnt_d;
         flt_clk_q    <= flt_clk_d;
         fall_q       <= fall_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         tmo_q        <= tmo_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         err_parity_q <= err_parity_d;
         err_frame_q  <= err_frame_d;
         led_q        <= led_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= evt_d;
   end

   assign evt_valid  = (level_q != '0);
   assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = level_q;
   assign led        = led_q;
   assign err_parity = err_parity_q;
   assign err_frame  = err_frame_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2key_evq.sv
// tb/tb_ps2key_evq.sv - self-checking bench for ps2key_evq
module tb_ps2key_evq;
   localparam int CLK_MHZ    = 1;
   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT_US = 150;
   localparam int DEPTH      = 4;
   localparam int TMO        = CLK_MHZ * TIMEOUT_US;
   localparam int HALF       = 12;
   localparam int GAP        = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       ps2_key_clk = 1'b1;
   logic       ps2_key_data = 1'b1;
   logic       evt_ready = 1'b0;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic [2:0] fifo_level;
   logic [7:0] led;
   logic       err_parity, err_frame, overflow;

   always #5 sys_clk = ~sys_clk;

   ps2key_evq #(.CLK_MHZ(CLK_MHZ), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(TIMEOUT_US),
                .FIFO_DEPTH(DEPTH)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_key_clk(ps2_key_clk),
      .ps2_key_data(ps2_key_data), .evt_data(evt_data), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .fifo_level(fifo_level), .led(led),
      .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow));

   typedef struct {
      logic [7:0] b;
      bit         bad_par;
      bit         bad_stop;
      bit         has_evt;
      logic [9:0] evt;
      bit         perr;
      bit         ferr;
      logic [7:0] led;
   } vec_t;

   vec_t       tbl[$];
   int         checks = 0;
   int         errors = 0;
   int         perr_seen = 0, ferr_seen = 0, perr_exp = 0, ferr_exp = 0;
   logic [9:0] exp_q[$];
   bit         rnd_ready = 0;
   bit         m_ext, m_brk, m_ovf;
   logic [7:0] m_led;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every cycle: observe error pulses and score each popped event against the expected queue.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         if (err_parity === 1'b1) perr_seen++;
         if (err_frame === 1'b1) ferr_seen++;
         if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL evt_unexpected: got %0h expected none", evt_data);
            end else begin
               check("evt_order", 32'(evt_data), 32'(exp_q[0]));
               exp_q.delete(0);
            end
         end
         @(posedge sys_clk);
         #1;
         if (rnd_ready) evt_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic ps2_bit(input logic v);
      ps2_key_data = v;
      tick(HALF);
      ps2_key_clk = 1'b0;
      tick(HALF);
      ps2_key_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      f = {logic'(~bad_stop), logic'((~^b) ^ bad_par), b, 1'b0};
      for (int i = 0; i < 11; i++) ps2_bit(f[i]);
      ps2_key_data = 1'b1;
      tick(GAP);
   endtask

   task automatic model_clear();
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   // Frame-level reference: prefix flags, make-only LED, bounded queue with sticky overflow.
   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      if (bad_stop) begin
         ferr_exp++;
         model_clear();
      end else if (bad_par) begin
         perr_exp++;
         model_clear();
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_brk) m_led = b;
         if (exp_q.size() < DEPTH) exp_q.push_back({logic'(m_ext), logic'(m_brk), b});
         else m_ovf = 1'b1;
         model_clear();
      end
   endtask

   task automatic model_send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input string name);
      model_frame(b, bad_par, bad_stop);
      send_frame(b, bad_par, bad_stop);
      check({name, "_perr"}, 32'(perr_seen), 32'(perr_exp));
      check({name, "_ferr"}, 32'(ferr_seen), 32'(ferr_exp));
      check({name, "_led"}, 32'(led), 32'(m_led));
   endtask

   task automatic do_reset(input string name);
      rnd_ready = 1'b0;
      evt_ready = 1'b0;
      ps2_key_data = 1'b1;
      sys_rst = 1'b1;
      tick(3);
      sys_rst = 1'b0;
      exp_q.delete();
      model_clear();
      m_ovf = 1'b0;
      m_led = 8'h00;
      tick(1);
      check({name, "_led"}, 32'(led), 32'h0);
      check({name, "_level"}, 32'(fifo_level), 32'h0);
      check({name, "_valid"}, 32'(evt_valid), 32'h0);
      check({name, "_data"}, 32'(evt_data), 32'h0);
      check({name, "_ovf"}, 32'(overflow), 32'h0);
      check({name, "_errs"}, 32'({err_parity, err_frame}), 32'h0);
   endtask

   initial begin
      int guard;
      logic [7:0] b;
      bit bp, bs;

      do_reset("rst0");

      // byte, bad_par, bad_stop, has_evt, evt, perr, ferr, led after
      tbl.push_back('{8'h1C, 0, 0, 1, 10'h01C, 0, 0, 8'h1C});
      tbl.push_back('{8'hE0, 0, 0, 0, 10'h000, 0, 0, 8'h1C});
      tbl.push_back('{8'hF0, 0, 0, 0, 10'h000, 0, 0, 8'h1C});
      tbl.push_back('{8'h75, 0, 0, 1, 10'h375, 0, 0, 8'h1C});
      tbl.push_back('{8'hE0, 0, 0, 0, 10'h000, 0, 0, 8'h1C});
      tbl.push_back('{8'h74, 0, 0, 1, 10'h274, 0, 0, 8'h74});
      tbl.push_back('{8'hF0, 0, 0, 0, 10'h000, 0, 0, 8'h74});
      tbl.push_back('{8'h1C, 1, 0, 0, 10'h000, 1, 0, 8'h74});
      tbl.push_back('{8'h32, 0, 0, 1, 10'h032, 0, 0, 8'h32});
      tbl.push_back('{8'hE0, 0, 0, 0, 10'h000, 0, 0, 8'h32});
      tbl.push_back('{8'h29, 0, 1, 0, 10'h000, 0, 1, 8'h32});
      tbl.push_back('{8'h1C, 0, 0, 1, 10'h01C, 0, 0, 8'h1C});
      tbl.push_back('{8'hF0, 0, 0, 0, 10'h000, 0, 0, 8'h1C});
      tbl.push_back('{8'h1C, 0, 0, 1, 10'h11C, 0, 0, 8'h1C});

      evt_ready = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].has_evt) exp_q.push_back(tbl[i].evt);
         perr_exp += int'(tbl[i].perr);
         ferr_exp += int'(tbl[i].ferr);
         send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
         check($sformatf("tbl%0d_perr", i), 32'(perr_seen), 32'(perr_exp));
         check($sformatf("tbl%0d_ferr", i), 32'(ferr_seen), 32'(ferr_exp));
         check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
         check($sformatf("tbl%0d_drain", i), 32'(exp_q.size()), 32'h0);
      end

      do_reset("rst1");
      evt_ready = 1'b1;

      // Start bit of 1 in IDLE is a framing error.
      ps2_bit(1'b1);
      tick(GAP);
      ferr_exp++;
      check("badstart_ferr", 32'(ferr_seen), 32'(ferr_exp));

      // A stalled frame times out and also clears a pending break prefix.
      model_send(8'hF0, 0, 0, "pre_f0");
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
      ps2_key_data = 1'b1;
      tick(TMO + 40);
      ferr_exp++;
      model_clear();
      check("tmo_ferr", 32'(ferr_seen), 32'(ferr_exp));
      model_send(8'h1C, 0, 0, "post_tmo");
      check("post_tmo_drain", 32'(exp_q.size()), 32'h0);

      // Full FIFO with consumer stalled: one extra make is dropped.
      evt_ready = 1'b0;
      model_send(8'h16, 0, 0, "ovf0");
      model_send(8'h1E, 0, 0, "ovf1");
      model_send(8'h26, 0, 0, "ovf2");
      model_send(8'h25, 0, 0, "ovf3");
      model_send(8'h2E, 0, 0, "ovf4");
      check("ovf_level", 32'(fifo_level), 32'(DEPTH));
      check("ovf_flag", 32'(overflow), 32'(m_ovf));
      check("ovf_head", 32'(evt_data), 32'(exp_q[0]));
      check("ovf_led", 32'(led), 32'h2E);
      evt_ready = 1'b1;
      tick(12);
      check("ovf_drain", 32'(exp_q.size()), 32'h0);
      check("ovf_level0", 32'(fifo_level), 32'h0);
      check("ovf_sticky", 32'(overflow), 32'h1);

      // Reset in the middle of a frame, then sub-filter glitches on the clock.
      evt_ready = 1'b0;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      do_reset("rst_mid");
      for (int g = 1; g < FILTER_LEN; g++) begin
         ps2_key_clk = 1'b0;
         tick(g);
         ps2_key_clk = 1'b1;
         tick(10);
      end
      tick(TMO + 20);
      check("glitch_perr", 32'(perr_seen), 32'(perr_exp));
      check("glitch_ferr", 32'(ferr_seen), 32'(ferr_exp));
      check("glitch_valid", 32'(evt_valid), 32'h0);
      check("glitch_led", 32'(led), 32'h0);
      evt_ready = 1'b1;
      model_send(8'h1C, 0, 0, "post_glitch");

      // Randomised frames against the model with a random-ready consumer.
      rnd_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bp = ($urandom_range(0, 7) == 0);
         bs = ($urandom_range(0, 7) == 0);
         guard = 0;
         while (exp_q.size() >= DEPTH && guard < 300) begin
            tick(1);
            guard++;
         end
         if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL rnd_drain_timeout: got %0d queued expected < %0d", exp_q.size(), DEPTH);
         end
         model_send(b, bp, bs, $sformatf("rnd%0d", n));
         tick($urandom_range(0, 30));
      end
      rnd_ready = 1'b0;
      evt_ready = 1'b1;
      tick(20);
      check("rnd_drain", 32'(exp_q.size()), 32'h0);
      check("rnd_level", 32'(fifo_level), 32'h0);
      check("rnd_ovf", 32'(overflow), 32'(m_ovf));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2key_evq.md
# ps2key_evq

Parametrised successor to the single-byte PS/2 keyboard receiver: deglitches the PS/2 clock, deframes 11-bit frames with full start/parity/stop checking and frame timeout, folds E0/F0 prefixes into single key events, and buffers the events in a first-word-fall-through FIFO with a valid/ready interface. Sits between the PS/2 pins and any consumer (LED display, UART bridge, CPU peripheral bus); its `led` output preserves the existing last-key LED function.

## Interface
- `CLK_MHZ`, 50, system clock frequency in MHz; used only to derive the timeout
- `FILTER_LEN`, 8, consecutive equal samples required before the filtered PS/2 clock changes level (2..255)
- `TIMEOUT_US`, 2000, max gap between falling PS/2 clock edges inside a frame
- `FIFO_DEPTH`, 16, event FIFO entries; power of two, 2..256
- `sys_clk`  in  1  system clock
- `sys_rst`  in  1  reset; synchronous, active-high
- `ps2_key_clk`  in  1  PS/2 clock pin, asynchronous
- `ps2_key_data`  in  1  PS/2 data pin, asynchronous
- `evt_data`  out  10  head event {ext, brk, code[7:0]}
- `evt_valid`  out  1  FIFO non-empty; `evt_data` valid
- `evt_ready`  in  1  consumer accepts head event when `evt_valid & evt_ready`
- `fifo_level`  out  log2(FIFO_DEPTH)+1  entries currently stored
- `led`  out  8  code byte of the most recent make (brk=0) event
- `err_parity`  out  1  one-cycle pulse: frame dropped for bad parity
- `err_frame`  out  1  one-cycle pulse: bad start/stop bit or timeout
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Input path: both pins pass a 2-FF synchroniser (reset value 1). Filtered clock changes level only after FILTER_LEN consecutive synchronised samples at the new level (reset value 1). A fall-edge strobe fires for one cycle when filtered clock goes 1→0; synchronised data is sampled on that cycle.
- Deframer states: IDLE, SHIFT, CHECK. IDLE: edge with data=0 → SHIFT, bit count 1; edge with data=1 → stay IDLE, pulse `err_frame`. SHIFT: 8 data bits LSB first, then parity, then stop; after stop bit (count 11) → CHECK. CHECK (one cycle): stop≠1 → `err_frame`; else odd parity over data+parity fails → `err_parity`; else byte accepted. Return to IDLE.
- Timeout: in SHIFT, a cycle counter of CLK_MHZ*TIMEOUT_US cycles restarts at each edge; on expiry → IDLE, pulse `err_frame`, discard partial byte.
- Prefix decoder: accepted byte 0xE0 sets ext flag, 0xF0 sets brk flag, neither produces an event. Any other byte produces event {ext, brk, byte} and clears both flags. Any error pulse or timeout also clears both flags.
- FIFO: push when event produced; push accepted if not full, or if full and a pop occurs in the same cycle. Dropped push sets `overflow` (cleared only by reset). Pop on `evt_valid & evt_ready`.
- `led` loads the code byte of every produced event with brk=0, whether or not the FIFO accepted it.

## Timing
- Reset: all outputs 0 (`led`=0x00, `fifo_level`=0, `evt_valid`=0, `overflow`=0), FIFO pointers 0, flags cleared, deframer IDLE, timeout counter 0. Reset mid-frame discards the frame; no error pulse.
- Edge strobe lags the pin fall by 2 (sync) + FILTER_LEN cycles.
- Stop-bit strobe at cycle N → CHECK at N+1 → FIFO write and `led` update registered at end of N+1 → `evt_valid`, `evt_data`, `fifo_level` updated at N+2. Error pulses high during cycle N+2.
- `evt_data` holds stable while `evt_valid & ~evt_ready`; next entry visible the cycle after a pop.
- Simultaneous push and pop: `fifo_level` unchanged; when empty, push only (no pop possible).
- Pointers wrap modulo FIFO_DEPTH; `fifo_level` reaches FIFO_DEPTH when full.

## Test plan
- Frame 0x1C (A), odd parity 0, stop 1, `evt_ready`=1 → one event 0x01C, `led`=0x1C, no error pulses.
- Sequence E0 F0 75 → exactly one event 0x375; `led` unchanged from previous value.
- Frame 0x1C with parity bit flipped, then valid 0x32 → `err_parity` pulse once, only event 0x032; preceding F0 flag cleared by the error.
- Stop after 5 data bits, idle > TIMEOUT_US → `err_frame` pulse, deframer IDLE; following valid 0x1C decodes normally.
- `evt_ready`=0, send FIFO_DEPTH+1 makes → `fifo_level`=FIFO_DEPTH, `overflow`=1, first FIFO_DEPTH codes drained in order, last lost; `led` shows last code.
- Assert `sys_rst` mid-frame and 1-cycle glitches (< FILTER_LEN) on PS/2 clock → no event, no error pulse, all outputs 0 after reset.
